// File: rtl/otter_intr_pkg.sv
// Shared types and register map for the OTTER multi-source interrupt controller.
package otter_intr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } intr_state_t;

    localparam logic [1:0] CFG_ENABLE  = 2'd0;
    localparam logic [1:0] CFG_EDGE    = 2'd1;
    localparam logic [1:0] CFG_PENDING = 2'd2;
    localparam logic [1:0] CFG_STATUS  = 2'd3;

endpackage

// File: rtl/otter_irq_sync.sv
// One interrupt source: SYNC_STAGES-deep synchroniser followed by a rising-edge detector.
module otter_irq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic IRQ,
    output logic LEVEL,
    output logic RISE
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // NOTE: non-blocking assignments so each stage samples its predecessor's old value.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], IRQ};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign LEVEL = sync_q[SYNC_STAGES-1];
    assign RISE  = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/otter_intr_ctrl.sv
// Multi-source interrupt controller: config registers, pending logic,
// fixed lowest-index-wins arbiter and the IDLE/REQ/SERVICE handshake FSM.
module otter_intr_ctrl
    import otter_intr_pkg::*;
#(
    parameter  int NUM_SRC     = 8,
    parameter  int SYNC_STAGES = 2,
    parameter  int VECTORED    = 1,
    localparam int ID_W        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic [NUM_SRC-1:0] IRQ_IN,
    input  logic               MIE,
    input  logic               INT_TAKEN,
    input  logic               INT_CLR,
    input  logic               CFG_WE,
    input  logic [1:0]         CFG_ADDR,
    input  logic [31:0]        CFG_WDATA,
    output logic [31:0]        CFG_RDATA,
    output logic               INT_REQ,
    output logic [ID_W-1:0]    INT_ID,
    output logic [31:0]        INT_VEC_OFF,
    output logic               IN_SERVICE
);

    localparam int EXT_W = 1 << ID_W;

    if (NUM_SRC < 1 || NUM_SRC > 32) begin : g_bad_num_src
        $error("otter_intr_ctrl: NUM_SRC must be in 1..32");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync_stages
        $error("otter_intr_ctrl: SYNC_STAGES must be in 2..3");
    end

    logic [NUM_SRC-1:0] level, rise;
    logic [NUM_SRC-1:0] enable_q, edge_mode_q, pending_q, eligible;
    logic [NUM_SRC-1:0] wdata_src;
    logic [EXT_W-1:0]   elig_ext;
    logic [ID_W-1:0]    id_q, winner;
    logic               latch_id, take_clr;
    logic               we_enable, we_edge, we_pending;
    intr_state_t        state_q, state_d;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        otter_irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .CLK     (CLK),
            .RESET_N (RESET_N),
            .IRQ     (IRQ_IN[g]),
            .LEVEL   (level[g]),
            .RISE    (rise[g])
        );
    end

    assign wdata_src  = NUM_SRC'(CFG_WDATA);
    assign we_enable  = CFG_WE && (CFG_ADDR == CFG_ENABLE);
    assign we_edge    = CFG_WE && (CFG_ADDR == CFG_EDGE);
    assign we_pending = CFG_WE && (CFG_ADDR == CFG_PENDING);
    assign take_clr   = (state_q == ST_REQ) && INT_TAKEN;

    // NOTE: config registers hold architectural state, so they get an explicit reset value.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            enable_q    <= '0;
            edge_mode_q <= '0;
        end else begin
            if (we_enable) enable_q    <= wdata_src;
            if (we_edge)   edge_mode_q <= wdata_src;
        end
    end

    // A rise outranks a W1C or take-clear landing in the same cycle.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pending_q <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (edge_mode_q[i]) begin
                    if (rise[i])
                        pending_q[i] <= 1'b1;
                    else if ((we_pending && wdata_src[i]) || (take_clr && ID_W'(i) == id_q))
                        pending_q[i] <= 1'b0;
                end else begin
                    pending_q[i] <= level[i];
                end
            end
        end
    end

    assign eligible = pending_q & enable_q;
    assign elig_ext = EXT_W'(eligible);

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        winner = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) winner = ID_W'(i);
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            if (latch_id) id_q <= winner;
        end
    end

    always_comb begin
        state_d  = state_q;
        latch_id = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (MIE && |eligible) begin
                    state_d  = ST_REQ;
                    latch_id = 1'b1;
                end
            end
            ST_REQ: begin
                if (INT_TAKEN)
                    state_d = ST_SERVICE;
                else if (!elig_ext[id_q] || !MIE)
                    state_d = ST_IDLE;
            end
            ST_SERVICE: begin
                if (INT_CLR) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        INT_REQ     = 1'b0;
        IN_SERVICE  = 1'b0;
        INT_VEC_OFF = '0;
        case (state_q)
            ST_REQ:     INT_REQ    = 1'b1;
            ST_SERVICE: IN_SERVICE = 1'b1;
            default: ;
        endcase
        if (VECTORED != 0 && state_q != ST_IDLE)
            INT_VEC_OFF = 32'({id_q, 2'b00});
    end

    assign INT_ID = id_q;

    always_comb begin
        CFG_RDATA = '0;
        case (CFG_ADDR)
            CFG_ENABLE:  CFG_RDATA = 32'(enable_q);
            CFG_EDGE:    CFG_RDATA = 32'(edge_mode_q);
            CFG_PENDING: CFG_RDATA = 32'(pending_q);
            CFG_STATUS:  CFG_RDATA = {28'b0, IN_SERVICE, INT_REQ, state_q};
            default:     CFG_RDATA = '0;
        endcase
    end

endmodule

// File: tb/tb_otter_intr_ctrl.sv
// Directed bench for otter_intr_ctrl: default build (8 sources, vectored) plus a
// 1-source non-vectored build sharing clock and reset.
module tb_otter_intr_ctrl;
    import otter_intr_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  irq_in = '0;
    logic        mie = 1'b0, int_taken = 1'b0, int_clr = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_addr = '0;
    logic [31:0] cfg_wdata = '0;
    logic [31:0] cfg_rdata, int_vec_off;
    logic        int_req, in_service;
    logic [2:0]  int_id;

    logic        s1_irq = 1'b0, s1_mie = 1'b0, s1_we = 1'b0;
    logic [1:0]  s1_addr = '0;
    logic [31:0] s1_wdata = '0;
    logic [31:0] s1_rdata, s1_vec_off;
    logic        s1_req, s1_in_service;
    logic [0:0]  s1_id;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    otter_intr_ctrl #(.NUM_SRC(8), .SYNC_STAGES(2), .VECTORED(1)) dut (
        .CLK(clk), .RESET_N(rst_n), .IRQ_IN(irq_in), .MIE(mie),
        .INT_TAKEN(int_taken), .INT_CLR(int_clr), .CFG_WE(cfg_we),
        .CFG_ADDR(cfg_addr), .CFG_WDATA(cfg_wdata), .CFG_RDATA(cfg_rdata),
        .INT_REQ(int_req), .INT_ID(int_id), .INT_VEC_OFF(int_vec_off),
        .IN_SERVICE(in_service)
    );

    otter_intr_ctrl #(.NUM_SRC(1), .SYNC_STAGES(2), .VECTORED(0)) dut_s1 (
        .CLK(clk), .RESET_N(rst_n), .IRQ_IN(s1_irq), .MIE(s1_mie),
        .INT_TAKEN(1'b0), .INT_CLR(1'b0), .CFG_WE(s1_we),
        .CFG_ADDR(s1_addr), .CFG_WDATA(s1_wdata), .CFG_RDATA(s1_rdata),
        .INT_REQ(s1_req), .INT_ID(s1_id), .INT_VEC_OFF(s1_vec_off),
        .IN_SERVICE(s1_in_service)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        cycle(1);
        cfg_we = 1'b0;
    endtask

    task automatic check_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
        cfg_addr = a;
        #1;
        check(tag, cfg_rdata, exp);
    endtask

    task automatic pulse_irq(input logic [7:0] m);
        irq_in = m;
        cycle(1);
        irq_in = '0;
    endtask

    task automatic take();
        int_taken = 1'b1; cycle(1); int_taken = 1'b0;
    endtask

    task automatic clr();
        int_clr = 1'b1; cycle(1); int_clr = 1'b0;
    endtask

    task automatic wait_req(input int budget, input string tag);
        int n = 0;
        while (!int_req && n < budget) begin
            cycle(1);
            n++;
        end
        check(tag, 32'(int_req), 32'd1);
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_req", 32'(int_req), 0);
        check("rst_svc", 32'(in_service), 0);
        check("rst_vec", int_vec_off, 0);
        check("rst_id", 32'(int_id), 0);
        #10 rst_n = 1'b1;
        cycle(1);
        check_reg("rst_status", CFG_STATUS, 0);
        check_reg("rst_enable", CFG_ENABLE, 0);

        // Bits above NUM_SRC are dropped
        cfg_write(CFG_ENABLE, 32'hFFFF_FFFF);
        check_reg("enable_mask", CFG_ENABLE, 32'hFF);
        cfg_write(CFG_EDGE, 32'hFF);
        check_reg("edge_rw", CFG_EDGE, 32'hFF);
        mie = 1'b1;

        // 1: single edge source 5, exact latency
        pulse_irq(8'h20);
        cycle(2);
        check_reg("t1_pending", CFG_PENDING, 32'h20);
        check("t1_req_early", 32'(int_req), 0);
        cycle(1);
        check("t1_req", 32'(int_req), 1);
        check("t1_id", 32'(int_id), 5);
        check("t1_vec", int_vec_off, 32'h14);
        take();
        check_reg("t1_pend_clr", CFG_PENDING, 0);
        check("t1_svc", 32'(in_service), 1);
        check("t1_req_low", 32'(int_req), 0);
        check_reg("t1_status_svc", CFG_STATUS, 32'hA);
        clr();
        check_reg("t1_status_idle", CFG_STATUS, 0);
        check("t1_vec_idle", int_vec_off, 0);

        // 2: simultaneous 6 and 2 -> 2 first, then 6
        pulse_irq(8'h44);
        wait_req(10, "t2_req_a");
        check("t2_id_a", 32'(int_id), 2);
        check("t2_vec_a", int_vec_off, 32'h8);
        take(); clr();
        wait_req(5, "t2_req_b");
        check("t2_id_b", 32'(int_id), 6);
        take(); clr();
        check_reg("t2_pend_empty", CFG_PENDING, 0);

        // 3: level source 3 withdrawn before take
        cfg_write(CFG_EDGE, 32'hF7);
        irq_in = 8'h08;
        wait_req(10, "t3_req");
        check("t3_id", 32'(int_id), 3);
        irq_in = '0;
        cycle(4);
        check("t3_withdrawn", 32'(int_req), 0);
        check("t3_no_trap", 32'(in_service), 0);
        check_reg("t3_pend", CFG_PENDING, 0);
        cfg_write(CFG_EDGE, 32'hFF);

        // 4: no nesting; src 0 accumulates while src 1 in service
        pulse_irq(8'h02);
        wait_req(10, "t4_req_a");
        check("t4_id_a", 32'(int_id), 1);
        take();
        pulse_irq(8'h01);
        cycle(4);
        check("t4_no_nest", 32'(int_req), 0);
        check("t4_still_svc", 32'(in_service), 1);
        check_reg("t4_pend", CFG_PENDING, 32'h01);
        clr();
        wait_req(5, "t4_req_b");
        check("t4_id_b", 32'(int_id), 0);
        take(); clr();

        // 5: rise beats same-cycle W1C; MIE gating; plain W1C withdraws
        mie = 1'b0;
        pulse_irq(8'h10);
        cycle(1);
        cfg_write(CFG_PENDING, 32'h10);
        check_reg("t5_set_wins", CFG_PENDING, 32'h10);
        cycle(2);
        check("t5_mie_off", 32'(int_req), 0);
        mie = 1'b1;
        cycle(1);
        check("t5_mie_on", 32'(int_req), 1);
        check("t5_id", 32'(int_id), 4);
        cfg_write(CFG_PENDING, 32'h10);
        cycle(1);
        check("t5_w1c_withdraw", 32'(int_req), 0);
        check_reg("t5_w1c_pend", CFG_PENDING, 0);

        // 6: async reset mid-service, no clock edge needed
        pulse_irq(8'h80);
        wait_req(10, "t6_req");
        take();
        check("t6_svc", 32'(in_service), 1);
        #1 rst_n = 1'b0;
        #1;
        check("t6_rst_svc", 32'(in_service), 0);
        check("t6_rst_req", 32'(int_req), 0);
        check_reg("t6_rst_enable", CFG_ENABLE, 0);
        rst_n = 1'b1;
        cycle(1);

        // Single-source, non-vectored build
        s1_we = 1'b1; s1_addr = CFG_ENABLE; s1_wdata = 32'hFFFF_FFFF;
        cycle(1);
        s1_addr = CFG_EDGE;
        cycle(1);
        s1_we = 1'b0; s1_addr = CFG_ENABLE;
        #1;
        check("s1_enable_mask", s1_rdata, 32'h1);
        s1_mie = 1'b1;
        s1_irq = 1'b1;
        cycle(1);
        s1_irq = 1'b0;
        for (int n = 0; n < 10 && !s1_req; n++) cycle(1);
        check("s1_req", 32'(s1_req), 1);
        check("s1_id", 32'(s1_id), 0);
        check("s1_vec_zero", s1_vec_off, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
